display_capture: RTL

Observer at the far end of the multiplexed 7-segment bus: watches the active-low `anode`/`cathode` lines that `display_driver` produces and reconstructs the four hex digits plus the display-on state. Used as a self-checking monitor in display benches and as an on-chip loop-back checker on the board build. Tolerates refresh-rate skew and segment glitches by requiring a settle window before every sample.

---
 rtl/display_pkg.sv | 44 ++++
 rtl/seg7_decode.sv | 40 ++++
 rtl/display_capture.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display path: active-low hex glyphs
// in {a,b,c,d,e,f,g} = bits 6..0 order, the capture FSM state type and a
// small helper for locating the single low anode bit.
package display_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_IDLE = 4'b1111;

  // WAIT: counting settle cycles, SAMPLE: act on settled value for one
  // cycle, HOLD: phase already sampled, wait for the next change.
  typedef enum logic [1:0] {
    CAP_WAIT   = 2'd0,
    CAP_SAMPLE = 2'd1,
    CAP_HOLD   = 2'd2
  } cap_state_t;

  // Index of the low bit of a one-cold anode word (caller checks one-cold).
  function automatic logic [1:0] low_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: active-low glyph -> {legal, nibble}.
// Anything that is not one of the sixteen hex glyphs (including blank) is
// reported illegal with nibble 0.
module seg7_decode
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  // Glyph lookup; default catches blank and every malformed pattern
  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: begin
        legal  = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Multiplexed 7-segment bus observer. Waits for anode/cathode to be stable
// for SETTLE_CYCLES, samples once per phase, assembles a four-digit frame in
// a shadow buffer and publishes it when every digit has been seen.
module display_capture
  import display_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned OFF_TIMEOUT   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cathode,
  input  logic [3:0] anode,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] digit_valid,
  output logic       display_on,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       anode_err
);

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [19:0] OFF_LIMIT   = 20'(OFF_TIMEOUT);

  // Input stage and change detection
  logic [3:0] a_q, a_d, a_prev_q, a_prev_d;
  logic [6:0] c_q, c_d, c_prev_q, c_prev_d;
  logic       change;

  // Settle counter and FSM
  logic [7:0] stab_cnt_q, stab_cnt_d;
  cap_state_t state_q, state_d;
  logic       sample_fire;

  // Frame assembly and outputs
  logic [19:0]      off_cnt_q, off_cnt_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  shadow_nib_q, shadow_nib_d;
  logic [3:0]       shadow_vld_q, shadow_vld_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       digit_valid_q, digit_valid_d;
  logic             display_on_q, display_on_d;
  logic             frame_valid_q, frame_valid_d;
  logic             seg_err_q, seg_err_d;
  logic             anode_err_q, anode_err_d;

  logic       dec_legal;
  logic [3:0] dec_nibble;
  logic [1:0] low_idx;

  seg7_decode u_decode (
    .seg    (c_q),
    .legal  (dec_legal),
    .nibble (dec_nibble)
  );

  assign change  = ({a_q, c_q} != {a_prev_q, c_prev_q});
  assign low_idx = low_index(a_q);

  // State register: FSM state plus every datapath flop
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q           <= ANODE_IDLE;
      c_q           <= SEG_BLANK;
      a_prev_q      <= ANODE_IDLE;
      c_prev_q      <= SEG_BLANK;
      stab_cnt_q    <= '0;
      state_q       <= CAP_WAIT;
      off_cnt_q     <= '0;
      seen_q        <= '0;
      shadow_nib_q  <= '0;
      shadow_vld_q  <= '0;
      digit_q       <= '0;
      digit_valid_q <= '0;
      display_on_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      a_q           <= a_d;
      c_q           <= c_d;
      a_prev_q      <= a_prev_d;
      c_prev_q      <= c_prev_d;
      stab_cnt_q    <= stab_cnt_d;
      state_q       <= state_d;
      off_cnt_q     <= off_cnt_d;
      seen_q        <= seen_d;
      shadow_nib_q  <= shadow_nib_d;
      shadow_vld_q  <= shadow_vld_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      display_on_q  <= display_on_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  // Input capture and saturating settle counter (restarts on any change)
  always_comb begin
    a_d      = anode;
    c_d      = cathode;
    a_prev_d = a_q;
    c_prev_d = c_q;
    if (change) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q == 8'hFF) begin
      stab_cnt_d = stab_cnt_q;
    end else begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end
  end

  // Next state: leave WAIT once the counter is about to reach SETTLE-1,
  // so the value seen in SAMPLE has been unchanged for SETTLE_CYCLES
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAP_WAIT: begin
        if (!change && stab_cnt_d >= SETTLE_LAST) state_d = CAP_SAMPLE;
      end
      CAP_SAMPLE: state_d = change ? CAP_WAIT : CAP_HOLD;
      CAP_HOLD:   state_d = change ? CAP_WAIT : CAP_HOLD;
      default:    state_d = CAP_WAIT;
    endcase
  end

  // FSM output: a change arriving in the SAMPLE cycle discards the sample
  always_comb begin
    sample_fire = (state_q == CAP_SAMPLE) && !change;
  end

  // Frame assembly, off detection and error pulses
  always_comb begin
    off_cnt_d     = off_cnt_q;
    seen_d        = seen_q;
    shadow_nib_d  = shadow_nib_q;
    shadow_vld_d  = shadow_vld_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    display_on_d  = display_on_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    anode_err_d   = 1'b0;

    if (a_q == ANODE_IDLE) begin
      off_cnt_d = (off_cnt_q == 20'hFFFFF) ? off_cnt_q : off_cnt_q + 20'd1;
    end else begin
      off_cnt_d = '0;
    end

    // Seen was completed last cycle: publish the shadow buffer
    if (seen_q == 4'b1111) begin
      digit_d       = shadow_nib_q;
      digit_valid_d = shadow_vld_q;
      frame_valid_d = 1'b1;
      seen_d        = '0;
    end

    // Display dark long enough: drop it and any partial frame
    if (off_cnt_q >= OFF_LIMIT) begin
      display_on_d = 1'b0;
      seen_d       = '0;
    end

    if (sample_fire) begin
      if ($onehot(~a_q)) begin
        shadow_nib_d[low_idx] = dec_legal ? dec_nibble : 4'h0;
        shadow_vld_d[low_idx] = dec_legal;
        seg_err_d             = !dec_legal;
        seen_d[low_idx]       = 1'b1;
        display_on_d          = 1'b1;
        off_cnt_d             = '0;
      end else if (a_q != ANODE_IDLE) begin
        anode_err_d = 1'b1;
      end
    end
  end

  assign digit3      = digit_q[3];
  assign digit2      = digit_q[2];
  assign digit1      = digit_q[1];
  assign digit0      = digit_q[0];
  assign digit_valid = digit_valid_q;
  assign display_on  = display_on_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign anode_err   = anode_err_q;

endmodule
